// File: rtl/ysyx_23060096_regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard.
// NRD combinational read ports with writeback bypass, one issue reservation
// and one writeback commit per cycle, flush of all reservations, and a
// registered count of reserved registers.
module ysyx_23060096_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic            wb_zero;
    logic            iss_zero;
    logic            wb_we;
    logic            iss_we;
    logic [AW-1:0]   ra;

    assign wb_zero  = (ZERO_REG != 0) && (wb_addr == '0);
    assign iss_zero = (ZERO_REG != 0) && (iss_addr == '0);
    assign wb_we    = wb_en && !wb_zero;
    assign iss_we   = iss_en && iss_ready && !iss_zero;
    assign busy_cnt = cnt_q;

    // A destination is reservable when idle or being released by this cycle's writeback
    always_comb begin
        iss_ready = 1'b1;
        if (!iss_zero) begin
            iss_ready = !busy_q[iss_addr] || (wb_en && (wb_addr == iss_addr));
        end
    end

    // Next busy vector: writeback clears, issue sets (wins on same address), flush clears all
    always_comb begin
        busy_d = busy_q;
        if (wb_we) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (iss_we) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Scoreboard state and reservation count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Register array; entry 0 is never written when hardwired to zero
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Read ports: hardwired zero, then same-cycle writeback bypass, then array/scoreboard
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end else if (wb_en && (wb_addr == ra)) begin
                rd_data[k*XLEN +: XLEN] = wb_data;
                rd_busy[k]              = 1'b0;
            end else begin
                rd_data[k*XLEN +: XLEN] = regs_q[ra];
                rd_busy[k]              = busy_q[ra];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_regfile_sb.sv
// Self-checking bench for ysyx_23060096_regfile_sb: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against
// an array-based model of register contents and reservations.
module tb_ysyx_23060096_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [XLEN-1:0] m_data [NREG];
    bit              m_busy [NREG];
    int              m_cnt    = 0;
    bit              seen_rst = 1'b0;

    always #5 clk = ~clk;

    ysyx_23060096_regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_ready(iss_ready), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .busy_cnt(busy_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs from the model state and the current inputs
    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_data[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (wb_en && wb_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit exp_ready();
        if (iss_addr == 0) return 1'b1;
        return !m_busy[iss_addr] || (wb_en && wb_addr == iss_addr);
    endfunction

    // Model update at each clock edge
    always @(posedge clk) begin
        bit rdy;
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                m_data[i] = '0;
                m_busy[i] = 1'b0;
            end
            seen_rst = 1'b1;
        end else begin
            rdy = exp_ready();
            if (wb_en && wb_addr != 0) begin
                m_data[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (iss_en && rdy && iss_addr != 0) m_busy[iss_addr] = 1'b1;
            if (flush) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end
        m_cnt = 0;
        for (int i = 0; i < NREG; i++) m_cnt += int'(m_busy[i]);
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (seen_rst) begin
            for (int k = 0; k < NRD; k++) begin
                chk($sformatf("model rd_data[%0d]", k), 64'(rd_data[k*XLEN +: XLEN]),
                    64'(exp_data(rd_addr[k*AW +: AW])));
                chk($sformatf("model rd_busy[%0d]", k), 64'(rd_busy[k]),
                    64'(exp_busy(rd_addr[k*AW +: AW])));
            end
            chk("model iss_ready", 64'(iss_ready), 64'(exp_ready()));
            chk("model busy_cnt", 64'(busy_cnt), 64'(m_cnt));
        end
    end

    task automatic step(input bit r, input bit ie, input int ia, input bit we, input int wa,
                        input logic [XLEN-1:0] wd, input bit fl, input int a0, input int a1);
        @(posedge clk);
        #1;
        rstn     = r;
        iss_en   = ie;
        iss_addr = AW'(ia);
        wb_en    = we;
        wb_addr  = AW'(wa);
        wb_data  = wd;
        flush    = fl;
        rd_addr  = {AW'(a1), AW'(a0)};
        #2;
    endtask

    initial begin
        rstn = 1'b0; iss_en = 1'b0; iss_addr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; flush = 1'b0; rd_addr = '0;

        // Reset then read every register on both ports
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 1; r < NREG; r++) begin
            step(1, 0, 0, 0, 0, 0, 0, r, NREG - r);
            chk("reset rd_data", 64'(rd_data), 64'd0);
            chk("reset rd_busy", 64'(rd_busy), 64'd0);
            chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
        end

        // Basic write/read, x0 hardwired, bypass
        step(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
        chk("bypass x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        step(1, 0, 0, 1, 0, 32'h1234, 0, 5, 0);
        chk("array x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("x0 during write", 64'(rd_data[63:32]), 64'd0);
        step(1, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("x5 readback", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("x0 readback", 64'(rd_data[63:32]), 64'd0);

        // Scoreboard reserve and release of x7
        step(1, 1, 7, 0, 0, 0, 0, 7, 0);
        chk("x7 ready before issue", 64'(iss_ready), 64'd1);
        step(1, 0, 7, 0, 0, 0, 0, 7, 7);
        chk("x7 busy", 64'(rd_busy), 64'd3);
        chk("x7 not ready", 64'(iss_ready), 64'd0);
        chk("cnt after x7", 64'(busy_cnt), 64'd1);
        step(1, 0, 7, 1, 7, 32'h55, 0, 7, 0);
        chk("x7 wb bypass busy", 64'(rd_busy[0]), 64'd0);
        chk("x7 wb bypass data", 64'(rd_data[31:0]), 64'h55);
        chk("x7 ready via wb", 64'(iss_ready), 64'd1);
        chk("cnt during x7 wb", 64'(busy_cnt), 64'd1);
        step(1, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("cnt after x7 wb", 64'(busy_cnt), 64'd0);
        chk("x7 data", 64'(rd_data[31:0]), 64'h55);

        // Same-cycle issue+writeback on busy x3, blocked issue of x9
        step(1, 1, 3, 0, 0, 0, 0, 3, 0);
        step(1, 1, 3, 1, 3, 32'hA1, 0, 3, 0);
        chk("x3 ready via wb", 64'(iss_ready), 64'd1);
        step(1, 0, 3, 0, 0, 0, 0, 3, 0);
        chk("x3 data", 64'(rd_data[31:0]), 64'hA1);
        chk("x3 still busy", 64'(rd_busy[0]), 64'd1);
        chk("cnt x3", 64'(busy_cnt), 64'd1);
        step(1, 1, 9, 0, 0, 0, 0, 9, 0);
        step(1, 1, 9, 0, 0, 0, 0, 9, 0);
        chk("x9 blocked", 64'(iss_ready), 64'd0);
        chk("cnt x3 x9", 64'(busy_cnt), 64'd2);
        step(1, 0, 0, 0, 0, 0, 0, 9, 3);
        chk("cnt after blocked issue", 64'(busy_cnt), 64'd2);
        chk("x9 x3 busy", 64'(rd_busy), 64'd3);

        // Flush beats issue, writeback still lands
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        step(1, 1, 6, 1, 2, 32'h77, 1, 2, 6);
        chk("cnt before flush", 64'(busy_cnt), 64'd5);
        chk("x2 bypass at flush", 64'(rd_data[31:0]), 64'h77);
        step(1, 0, 6, 0, 0, 0, 0, 2, 6);
        chk("cnt after flush", 64'(busy_cnt), 64'd0);
        chk("x2 after flush", 64'(rd_data[31:0]), 64'h77);
        chk("x2 x6 not busy", 64'(rd_busy), 64'd0);
        chk("x6 ready", 64'(iss_ready), 64'd1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 4);
        chk("x1 x4 not busy", 64'(rd_busy), 64'd0);

        // Reset mid-operation overrides issue and writeback
        step(1, 1, 10, 0, 0, 0, 0, 0, 0);
        step(1, 1, 11, 0, 0, 0, 0, 0, 0);
        step(1, 1, 12, 0, 0, 0, 0, 0, 0);
        step(0, 1, 13, 1, 10, 32'hFF, 0, 10, 5);
        chk("cnt before reset", 64'(busy_cnt), 64'd3);
        step(1, 0, 13, 0, 0, 0, 0, 10, 5);
        chk("data after reset", 64'(rd_data), 64'd0);
        chk("busy after reset", 64'(rd_busy), 64'd0);
        chk("cnt after reset", 64'(busy_cnt), 64'd0);
        chk("x13 ready after reset", 64'(iss_ready), 64'd1);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            int ia, wa, a0, a1;
            ia = int'($urandom_range(0, NREG - 1));
            wa = ($urandom_range(0, 3) == 0) ? ia : int'($urandom_range(0, NREG - 1));
            a0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NREG - 1));
            a1 = ($urandom_range(0, 3) == 0) ? ia : int'($urandom_range(0, NREG - 1));
            step($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, ia,
                 $urandom_range(0, 2) == 0, wa, $urandom, $urandom_range(0, 31) == 0, a0, a1);
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ysyx_23060096_regfile_sb.md
# ysyx_23060096_regfile_sb

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, serving the pipelined NPC core. Decode reads operands through NRD combinational ports and gets a busy flag per operand. Issue reserves a destination register. Writeback commits data and releases the reservation, with same-cycle write-through bypass. A flush drops all reservations on a pipeline redirect.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREG), register address width
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero, is never written and is never busy

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*AW  packed read addresses; port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data; port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  port k operand has a pending write not yet committed
- iss_en  in  1  reserve register iss_addr as the destination of an in-flight instruction
- iss_addr  in  AW  destination to reserve
- iss_ready  out  1  iss_addr can be reserved this cycle
- wb_en  in  1  commit wb_data to wb_addr
- wb_addr  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  clear all reservations
- busy_cnt  out  AW+1  number of registers currently reserved (registered)

## Operation
- Storage: NREG x XLEN array plus an NREG-bit busy vector. With ZERO_REG=1, entry 0 is constant zero and busy[0] is constant 0.
- Read port k, combinational:
  - Address 0 with ZERO_REG=1: rd_data=0, rd_busy=0.
  - Else if wb_en and wb_addr==rd_addr[k]: rd_data=wb_data, rd_busy=0 (bypass).
  - Else: rd_data=array[rd_addr[k]], rd_busy=busy[rd_addr[k]].
- iss_ready = !busy[iss_addr] || (wb_en && wb_addr==iss_addr). Register 0 with ZERO_REG=1 is always ready.
- An iss_en with iss_ready=0 is ignored: no state change. The issuing stage must stall.
- Writeback: on wb_en, array[wb_addr]<=wb_data and busy[wb_addr]<=0. A writeback to a non-busy register is legal and writes data. Writes to register 0 with ZERO_REG=1 are dropped.
- Issue: on iss_en && iss_ready, busy[iss_addr]<=1. Writes to register 0 with ZERO_REG=1 are dropped.
- Same-address issue and writeback in one cycle: the data is written, and busy ends at 1 (issue wins).
- Flush: busy<=0 for all registers. Flush beats an issue in the same cycle. A writeback in the same cycle still writes data.
- busy_cnt is the population count of the next-state busy vector, registered. It is always ≤ NREG-ZERO_REG.
- Reset (rstn=0 at posedge): all array entries 0, busy all 0, busy_cnt 0. Reset overrides wb_en, iss_en and flush in the same cycle.

## Timing
- Reads: zero latency. Array and busy changes become visible the cycle after the edge; bypassed wb_data is visible in the same cycle.
- iss_ready: combinational from iss_addr, busy and the wb inputs. There is no path from iss_en to iss_ready.
- busy_cnt reflects the state after the previous edge, with one cycle of latency.
- Reset mid-operation: outstanding reservations are lost. From the first cycle after reset, all outputs read 0 and all registers are ready.
- Max one issue and one writeback per cycle.

## Test plan
- Reset then read: drive rstn=0 for 1 cycle, then read regs 1..31 on all ports -> rd_data=0, rd_busy=0, busy_cnt=0.
- Basic write/read and x0: wb x5=0xDEADBEEF and x0=0x1234, then read x5 and x0 next cycle -> 0xDEADBEEF and 0. Same-cycle read of x5 during the write -> 0xDEADBEEF via bypass.
- Scoreboard: issue x7 -> next cycle rd_busy=1 for x7, iss_ready=0 for x7, busy_cnt=1. Then wb x7=0x55 -> same cycle rd_busy=0 and rd_data=0x55; next cycle busy_cnt=0.
- Simultaneous events on x3 (busy): issue x3 + wb x3=0xA1 in one cycle -> data 0xA1 stored, x3 still busy. Blocked issue of busy x9 -> ignored, busy_cnt unchanged.
- Flush: reserve x1, x2, x4, then flush with a same-cycle issue of x6 and wb x2=0x77 -> all busy 0, busy_cnt=0, x2 reads 0x77, x6 not busy.
- Reset mid-operation: reserve 3 regs, assert rstn=0 together with iss_en and wb_en -> next cycle all data 0, busy 0, busy_cnt 0.
